// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants, types and round-robin helper for the write arbiter
package regfile_write_arbiter_pkg;

  localparam int NCLIENT = 3;

  typedef logic [1:0] cidx_t;

  // Advance a client index, wrapping at NCLIENT; out-of-range values wrap to 0.
  function automatic cidx_t rr_next(input cidx_t i);
    if (i >= cidx_t'(NCLIENT - 1)) begin
      return cidx_t'(0);
    end
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick3.sv
// rtl/regfile_write_arbiter_rr_pick3.sv - three-way round-robin picker, first eligible index from ptr
module rr_pick3
  import regfile_write_arbiter_pkg::*;
(
  input  logic [NCLIENT-1:0] elig,
  input  cidx_t              ptr,
  output cidx_t              grant,
  output logic               any
);

  cidx_t idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = (ptr >= cidx_t'(NCLIENT)) ? cidx_t'(0) : ptr;
    for (int k = 0; k < NCLIENT; k++) begin
      if (!any && elig[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - funnels three write clients into the register file write port
// with per-address acceptance ordering and a youngest-pending bypass read.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int size  = 1,
  parameter int width = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_req0,
  input  logic             EN_req1,
  input  logic             EN_req2,
  input  logic [size-1:0]  req0_x,
  input  logic [size-1:0]  req1_x,
  input  logic [size-1:0]  req2_x,
  input  logic [width-1:0] req0_y,
  input  logic [width-1:0] req1_y,
  input  logic [width-1:0] req2_y,
  output logic             RDY_req0,
  output logic             RDY_req1,
  output logic             RDY_req2,
  output logic [size-1:0]  upd_x,
  output logic [width-1:0] upd_y,
  output logic             EN_upd,
  input  logic             RDY_upd,
  input  logic [size-1:0]  byp_x,
  output logic [width-1:0] byp,
  output logic             byp_hit,
  output logic             idle
);

  logic [NCLIENT-1:0] slot_v;
  logic [size-1:0]    slot_a [NCLIENT];
  logic [width-1:0]   slot_d [NCLIENT];
  // older[j][i] set means slot j was accepted before slot i
  logic [NCLIENT-1:0] older   [NCLIENT];
  logic [NCLIENT-1:0] older_n [NCLIENT];
  cidx_t              ptr;

  logic [NCLIENT-1:0] en_req;
  logic [NCLIENT-1:0] acc;
  logic [NCLIENT-1:0] elig;
  logic [NCLIENT-1:0] fire_vec;
  logic [NCLIENT-1:0] match;
  logic [NCLIENT-1:0] youngest;
  logic [size-1:0]    req_x [NCLIENT];
  logic [width-1:0]   req_y [NCLIENT];
  cidx_t              grant;
  logic               any_elig;
  logic               fire;

  assign en_req   = {EN_req2, EN_req1, EN_req0};
  assign req_x[0] = req0_x;
  assign req_x[1] = req1_x;
  assign req_x[2] = req2_x;
  assign req_y[0] = req0_y;
  assign req_y[1] = req1_y;
  assign req_y[2] = req2_y;

  assign RDY_req0 = ~slot_v[0];
  assign RDY_req1 = ~slot_v[1];
  assign RDY_req2 = ~slot_v[2];
  assign acc      = en_req & ~slot_v;
  assign idle     = ~|slot_v;

  // A slot waits while any older pending slot targets the same address.
  always_comb begin
    for (int i = 0; i < NCLIENT; i++) begin
      elig[i] = slot_v[i];
      for (int j = 0; j < NCLIENT; j++) begin
        if (j != i && slot_v[j] && older[j][i] && (slot_a[j] == slot_a[i])) begin
          elig[i] = 1'b0;
        end
      end
    end
  end

  rr_pick3 u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .any   (any_elig)
  );

  assign EN_upd = any_elig;
  assign fire   = any_elig & RDY_upd;
  assign upd_x  = any_elig ? slot_a[grant] : '0;
  assign upd_y  = any_elig ? slot_d[grant] : '0;

  always_comb begin
    fire_vec = '0;
    if (fire) begin
      fire_vec[grant] = 1'b1;
    end
  end

  // Simultaneous accepts order by client index; a draining slot is not older than a newcomer.
  always_comb begin
    for (int j = 0; j < NCLIENT; j++) begin
      for (int i = 0; i < NCLIENT; i++) begin
        if (j == i) begin
          older_n[j][i] = 1'b0;
        end else if (acc[i]) begin
          older_n[j][i] = (slot_v[j] & ~fire_vec[j]) | (acc[j] & (j < i));
        end else if (acc[j] || fire_vec[i]) begin
          older_n[j][i] = 1'b0;
        end else begin
          older_n[j][i] = older[j][i];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_v <= '0;
      ptr    <= '0;
      for (int i = 0; i < NCLIENT; i++) begin
        older[i]  <= '0;
        slot_a[i] <= '0;
        slot_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCLIENT; i++) begin
        older[i] <= older_n[i];
        if (acc[i]) begin
          slot_v[i] <= 1'b1;
          slot_a[i] <= req_x[i];
          slot_d[i] <= req_y[i];
        end else if (fire_vec[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
      if (fire) begin
        ptr <= rr_next(grant);
      end
    end
  end

  // Among matching slots the youngest is the one no other match is younger than.
  always_comb begin
    byp = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      match[i] = slot_v[i] && (slot_a[i] == byp_x);
    end
    for (int i = 0; i < NCLIENT; i++) begin
      youngest[i] = match[i];
      for (int k = 0; k < NCLIENT; k++) begin
        if (k != i && match[k] && older[i][k]) begin
          youngest[i] = 1'b0;
        end
      end
      if (youngest[i]) begin
        byp = byp | slot_d[i];
      end
    end
  end

  assign byp_hit = |match;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int SZ = 5;
  localparam int WD = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    en;
  logic [2:0]    rdy;
  logic [SZ-1:0] rx [3];
  logic [WD-1:0] ry [3];
  logic [SZ-1:0] upd_x;
  logic [WD-1:0] upd_y;
  logic          EN_upd;
  logic          RDY_upd;
  logic [SZ-1:0] byp_x;
  logic [WD-1:0] byp;
  logic          byp_hit;
  logic          idle;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [SZ-1:0] x;
    logic [WD-1:0] y;
  } wr_t;

  typedef struct {
    int            c;
    logic [SZ-1:0] x;
    logic [WD-1:0] y;
  } vec_t;

  wr_t  exp_q [$];
  wr_t  mon_w;
  vec_t vecs [4];
  int   kc [3];

  regfile_write_arbiter #(.size(SZ), .width(WD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN_req0  (en[0]),
    .EN_req1  (en[1]),
    .EN_req2  (en[2]),
    .req0_x   (rx[0]),
    .req1_x   (rx[1]),
    .req2_x   (rx[2]),
    .req0_y   (ry[0]),
    .req1_y   (ry[1]),
    .req2_y   (ry[2]),
    .RDY_req0 (rdy[0]),
    .RDY_req1 (rdy[1]),
    .RDY_req2 (rdy[2]),
    .upd_x    (upd_x),
    .upd_y    (upd_y),
    .EN_upd   (EN_upd),
    .RDY_upd  (RDY_upd),
    .byp_x    (byp_x),
    .byp      (byp),
    .byp_hit  (byp_hit),
    .idle     (idle)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    en      = 3'b000;
    RDY_upd = 1'b1;
    byp_x   = '0;
    for (int c = 0; c < 3; c++) begin
      rx[c] = '0;
      ry[c] = '0;
    end
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Commit monitor: every register-file write must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      for (int c = 0; c < 3; c++) begin
        if (en[c] && !rdy[c]) begin
          checks++;
          errors++;
          $display("FAIL protocol: client %0d enabled while slot busy", c);
        end
      end
      if (EN_upd && RDY_upd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit: unexpected write x=%0h y=%0h", upd_x, upd_y);
        end else begin
          mon_w = exp_q.pop_front();
          chk("commit_x", 64'(upd_x), 64'(mon_w.x));
          chk("commit_y", 64'(upd_y), 64'(mon_w.y));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{c: 1, x: 5'd3,  y: 32'h0000_00A5};
    vecs[1] = '{c: 0, x: 5'd0,  y: 32'h0000_0000};
    vecs[2] = '{c: 1, x: 5'd17, y: 32'h1234_5678};
    vecs[3] = '{c: 2, x: 5'd31, y: 32'hFFFF_FFFF};

    // Reset state
    do_reset();
    @(negedge CLK);
    chk("rst_idle",    64'(idle),    64'd1);
    chk("rst_en_upd",  64'(EN_upd),  64'd0);
    chk("rst_rdy",     64'(rdy),     64'h7);
    chk("rst_byp_hit", 64'(byp_hit), 64'd0);
    chk("rst_byp",     64'(byp),     64'd0);
    chk("rst_upd_x",   64'(upd_x),   64'd0);
    chk("rst_upd_y",   64'(upd_y),   64'd0);

    // Single writes from a table
    for (int n = 0; n < 4; n++) begin
      step();
      en[vecs[n].c] = 1'b1;
      rx[vecs[n].c] = vecs[n].x;
      ry[vecs[n].c] = vecs[n].y;
      byp_x         = vecs[n].x;
      exp_q.push_back('{x: vecs[n].x, y: vecs[n].y});
      step();
      en = 3'b000;
      @(negedge CLK);
      chk("single_rdy_busy", 64'(rdy[vecs[n].c]), 64'd0);
      chk("single_en_upd",   64'(EN_upd),         64'd1);
      chk("single_upd_x",    64'(upd_x),          64'(vecs[n].x));
      chk("single_upd_y",    64'(upd_y),          64'(vecs[n].y));
      chk("single_byp_hit",  64'(byp_hit),        64'd1);
      chk("single_byp",      64'(byp),            64'(vecs[n].y));
      chk("single_not_idle", 64'(idle),           64'd0);
      step();
      @(negedge CLK);
      chk("single_rdy_free", 64'(rdy[vecs[n].c]), 64'd1);
      chk("single_idle",     64'(idle),           64'd1);
      chk("single_byp_miss", 64'(byp_hit),        64'd0);
    end

    // Round-robin fairness: commits must interleave 0,1,2,0,1,2,...
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back('{x: SZ'(c * 8 + k), y: WD'(32'hF000_0000 + c * 256 + k)});
      end
    end
    for (int c = 0; c < 3; c++) kc[c] = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        if (rdy[c] && kc[c] < 4) begin
          en[c] = 1'b1;
          rx[c] = SZ'(c * 8 + kc[c]);
          ry[c] = WD'(32'hF000_0000 + c * 256 + kc[c]);
          kc[c]++;
        end else begin
          en[c] = 1'b0;
        end
      end
      @(negedge CLK);
      if (cyc >= 1 && cyc <= 12) chk("rr_en_upd", 64'(EN_upd), 64'd1);
    end
    chk("rr_drained", 64'(exp_q.size()), 64'd0);
    chk("rr_idle",    64'(idle),         64'd1);

    // Same-address ordering across clients, older one drains first
    do_reset();
    exp_q.push_back('{x: 5'd7, y: 32'd1});
    exp_q.push_back('{x: 5'd7, y: 32'd2});
    step();
    en[2] = 1'b1; rx[2] = 5'd7; ry[2] = 32'd1;
    byp_x = 5'd7;
    step();
    en[2] = 1'b0;
    en[0] = 1'b1; rx[0] = 5'd7; ry[0] = 32'd2;
    @(negedge CLK);
    chk("same_byp_t1",   64'(byp),     64'd1);
    chk("same_hit_t1",   64'(byp_hit), 64'd1);
    chk("same_upd_y_t1", 64'(upd_y),   64'd1);
    step();
    en = 3'b000;
    @(negedge CLK);
    chk("same_byp_t2",   64'(byp),     64'd2);
    chk("same_upd_y_t2", 64'(upd_y),   64'd2);
    step();
    @(negedge CLK);
    chk("same_idle", 64'(idle), 64'd1);

    // Both same-address writes pending: the younger is blocked despite ptr favouring it
    do_reset();
    RDY_upd = 1'b0;
    step();
    en[2] = 1'b1; rx[2] = 5'd7; ry[2] = 32'd1;
    byp_x = 5'd7;
    step();
    en[2] = 1'b0;
    en[0] = 1'b1; rx[0] = 5'd7; ry[0] = 32'd2;
    step();
    en = 3'b000;
    @(negedge CLK);
    chk("age_byp_youngest", 64'(byp),   64'd2);
    chk("age_upd_x",        64'(upd_x), 64'd7);
    chk("age_upd_y_older",  64'(upd_y), 64'd1);
    chk("age_rdy",          64'(rdy),   64'h2);
    exp_q.push_back('{x: 5'd7, y: 32'd1});
    exp_q.push_back('{x: 5'd7, y: 32'd2});
    step();
    RDY_upd = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk("age_drained", 64'(exp_q.size()), 64'd0);
    chk("age_idle",    64'(idle),         64'd1);

    // Backpressure holds the offered write stable and drains nothing
    do_reset();
    RDY_upd = 1'b0;
    step();
    en = 3'b011;
    rx[0] = 5'd4; ry[0] = 32'h44;
    rx[1] = 5'd5; ry[1] = 32'h55;
    step();
    en = 3'b000;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      chk("bp_en_upd", 64'(EN_upd), 64'd1);
      chk("bp_upd_x",  64'(upd_x),  64'd4);
      chk("bp_upd_y",  64'(upd_y),  64'h44);
      chk("bp_rdy",    64'(rdy),    64'h4);
      step();
    end
    exp_q.push_back('{x: 5'd4, y: 32'h44});
    exp_q.push_back('{x: 5'd5, y: 32'h55});
    RDY_upd = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_idle",    64'(idle),         64'd1);

    // Asynchronous reset with three slots pending discards them
    do_reset();
    RDY_upd = 1'b0;
    step();
    en = 3'b111;
    rx[0] = 5'd10; ry[0] = 32'hA0;
    rx[1] = 5'd11; ry[1] = 32'hB0;
    rx[2] = 5'd12; ry[2] = 32'hC0;
    step();
    en = 3'b000;
    @(negedge CLK);
    chk("arst_pre_rdy",    64'(rdy),    64'h0);
    chk("arst_pre_en_upd", 64'(EN_upd), 64'd1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_en_upd", 64'(EN_upd), 64'd0);
    chk("arst_idle",   64'(idle),   64'd1);
    chk("arst_rdy",    64'(rdy),    64'h7);
    RDY_upd = 1'b1;
    step();
    step();
    RST = 1'b0;
    repeat (4) step();
    @(negedge CLK);
    chk("arst_post_idle", 64'(idle), 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
